axi4_mem_responder: RTL and testbench
=====================================

# axi4_mem_responder

AXI4 responder (slave) backed by on-chip block RAM. It is the far-end counterpart of the AXI4 test initiators that drive an `axi4_ifc` master port. It accepts write and read bursts, stores and returns data with byte-strobe support, and reports OKAY or SLVERR. It is used as a simulation and loopback target for initiator self-tests and as a small scratch memory in fabric designs.

## Interface
- `ADDR_WIDTH`, default 10: log2 of memory depth in 32-bit words (default 4 KiB).
- `DATA_WIDTH`, default 32: data bus width. Only 32 is supported.
- `clk`, input, 1: the single clock for the block.
- `reset`, input, 1: synchronous, active-high reset.
- `s`, interface, `axi4_ifc`: responder side.
  - Driven by this block: awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid.
  - All other fields are sampled.
  - ID, LOCK, CACHE, PROT and QOS are ignored; all IDs are treated as 0.

## Operation
- **Addressing**
  - Word index = axaddr[ADDR_WIDTH+1:2]. Upper bits and axaddr[1:0] are ignored.
  - The index wraps modulo 2^ADDR_WIDTH.
- **Burst address update**
  - INCR: index +1 per beat.
  - FIXED: index held for all beats.
  - Beats per burst = axlen+1 (1..256).
- **Write FSM**
  - W_IDLE: awready=1. On AW handshake, latch address, len and burst; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the RAM using wstrb as byte enables. After beat axlen+1, go to W_RESP. Termination is by count; wlast does not end the burst.
  - W_RESP: bvalid=1 and bresp held until the bready handshake, then go to W_IDLE.
- **Read FSM**
  - R_IDLE: arready=1. On AR handshake, latch fields; go to R_FETCH.
  - R_FETCH: RAM read issued; go to R_DATA.
  - R_DATA: rvalid=1; rdata, rresp and rlast held. rlast=1 only on beat arlen+1.
  - On R handshake: next beat goes to R_FETCH; last beat goes to R_IDLE.
- **Channel independence**
  - The read and write FSMs run concurrently.
  - The RAM has one write port and one read port.
  - Same-cycle read and write of the same word returns old data (read-first).
- **Reset**
  - All outputs are 0: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata.
  - Both FSMs go to IDLE.
  - RAM contents are not cleared.
  - Reset mid-burst aborts the transaction with no response. Beats already written stay in memory.

## Timing
- awready and arready are registered. They rise in the first cycle after reset deasserts, and drop the cycle after their handshake.
- Write data throughput is 1 beat/cycle. bvalid rises the cycle after the last W handshake.
- First rvalid comes 2 cycles after the AR handshake.
- Each subsequent rvalid comes 2 cycles after the previous R handshake, giving 1 beat per 2 cycles.
- Under backpressure (rready=0 or bready=0), rvalid/rdata/rresp/rlast and bvalid/bresp stay stable.
- A W beat presented before the AW handshake is not accepted: wready=0 outside W_DATA.

## Configuration
- Macro: `AXI4_MEM_RESPONDER_CHECK_EN`.
- **Defined:** protocol checks are active.
  - axsize≠2 or burst=WRAP/reserved: the burst is consumed but memory is not written, and the response is SLVERR. For reads, rdata=0 and rresp=SLVERR on every beat.
  - wlast mismatch (asserted early, or absent on the final beat): the memory write proceeds and bresp=SLVERR.
- **Undefined:** no checks.
  - Size is ignored (treated as 4 bytes).
  - WRAP and reserved burst types are treated as INCR.
  - All responses are OKAY.

## Structure
- Package `axi4_pkg` holds:
  - Burst constants: BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
  - Response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - The write and read FSM state enums.
- Sub-module `axi4_mem_ram`: simple dual-port, read-first, byte-write-enable synchronous RAM with registered read data. Parameters are ADDR_WIDTH and DATA_WIDTH.

## Test plan
- **Single beat:**
  - Write awaddr=0x10, len 0, wdata=0xDEADBEEF, wstrb=0xF → bvalid one cycle after the W handshake, bresp=OKAY.
  - Read 0x10 → rvalid 2 cycles after AR, rdata=0xDEADBEEF, rlast=1.
- **INCR burst:**
  - Write 16 beats at 0x100 with data=beat index.
  - Read 16 beats at 0x100 → data 0..15 in order, rlast only on beat 16.
  - Also: FIXED 4-beat write to 0x40 → reads back the last beat's data.
- **Strobes:**
  - Write 0xFFFFFFFF, then write 0x00000000 with wstrb=0x5.
  - Read → 0xFF00FF00.
- **Backpressure:** hold bready and rready low for 5 cycles → bvalid, rvalid, rdata and rlast stay stable; no beat is lost or duplicated.
- **Checks:**
  - With CHECK_EN: awsize=1, or wlast on beat 2 of 4 → bresp=SLVERR. For awsize=1, memory is unchanged.
  - Without CHECK_EN: the same stimulus gives OKAY.
- **Reset mid-write:**
  - Assert reset after beat 3 of an 8-beat burst → no bvalid; beats 1-3 are readable.
  - The next full transaction completes with OKAY.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, FSM state types and burst helpers for the memory responder.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

  // Only FIXED holds the index; WRAP and reserved step like INCR.
  function automatic logic burst_advances(input logic [1:0] burst);
    return burst != BURST_FIXED;
  endfunction

  function automatic logic burst_legal(input logic [1:0] burst);
    return !((burst == BURST_WRAP) || (burst == 2'b11));
  endfunction

endpackage

// File: rtl/axi4_ifc.sv
// AXI4 bundle; the responder uses the slave modport. IDs are carried but not echoed.
interface axi4_ifc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, read-first registered read port.
module axi4_mem_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  localparam int Depth = 2 ** ADDR_WIDTH;
  localparam int StrbW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Registered read; a same-cycle write to the same word returns the old value.
  always_ff @(posedge i_clk) begin
    if (i_reset)   r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 responder backed by block RAM with independent write and read FSMs.
// Define AXI4_MEM_RESPONDER_CHECK_EN to enable size/burst/wlast protocol checks (SLVERR).
module axi4_mem_responder
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic    clk,
  input logic    reset,
  axi4_ifc.slave s
);
  wr_state_e             r_wstate;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen, r_wcnt;
  logic                  r_wadv, r_wfatal, r_wlast_err;
  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;

  rd_state_e             r_rstate;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen, r_rcnt;
  logic                  r_radv, r_rfatal;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [1:0]            r_rresp;

  logic                  w_w_fire, w_wbeat_last, w_wlast_bad, w_aw_fatal, w_ar_fatal;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic                  w_unused;

  assign w_w_fire     = r_wready && s.wvalid;
  assign w_wbeat_last = (r_wcnt == r_wlen);

`ifdef AXI4_MEM_RESPONDER_CHECK_EN
  assign w_aw_fatal  = (s.awsize != 3'd2) || !burst_legal(s.awburst);
  assign w_ar_fatal  = (s.arsize != 3'd2) || !burst_legal(s.arburst);
  assign w_wlast_bad = (s.wlast != w_wbeat_last);
`else
  assign w_aw_fatal  = 1'b0;
  assign w_ar_fatal  = 1'b0;
  assign w_wlast_bad = 1'b0;
`endif

  // Write channel: accept AW, count W beats by awlen, then hold B until bready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_waddr     <= '0;
      r_wlen      <= '0;
      r_wcnt      <= '0;
      r_wadv      <= 1'b0;
      r_wfatal    <= 1'b0;
      r_wlast_err <= 1'b0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (r_awready && s.awvalid) begin
            r_awready   <= 1'b0;
            r_wready    <= 1'b1;
            r_waddr     <= s.awaddr[ADDR_WIDTH+1:2];
            r_wlen      <= s.awlen;
            r_wcnt      <= '0;
            r_wadv      <= burst_advances(s.awburst);
            r_wfatal    <= w_aw_fatal;
            r_wlast_err <= 1'b0;
            r_wstate    <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_fire) begin
            if (r_wadv) r_waddr <= r_waddr + ADDR_WIDTH'(1);
            r_wcnt <= r_wcnt + 8'd1;
            if (w_wlast_bad) r_wlast_err <= 1'b1;
            if (w_wbeat_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_wfatal || r_wlast_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s.bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel: one RAM fetch cycle per beat, then hold R until rready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_radv    <= 1'b0;
      r_rfatal  <= 1'b0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (r_arready && s.arvalid) begin
            r_arready <= 1'b0;
            r_raddr   <= s.araddr[ADDR_WIDTH+1:2];
            r_rlen    <= s.arlen;
            r_rcnt    <= '0;
            r_radv    <= burst_advances(s.arburst);
            r_rfatal  <= w_ar_fatal;
            r_rstate  <= R_FETCH;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_FETCH: begin
          r_rvalid <= 1'b1;
          r_rlast  <= (r_rcnt == r_rlen);
          r_rresp  <= r_rfatal ? RESP_SLVERR : RESP_OKAY;
          r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (s.rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rresp  <= RESP_OKAY;
            if (r_rlast) begin
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rcnt   <= r_rcnt + 8'd1;
              if (r_radv) r_raddr <= r_raddr + ADDR_WIDTH'(1);
              r_rstate <= R_FETCH;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axi4_mem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (clk),
    .i_reset (reset),
    .i_we    (w_w_fire && !r_wfatal),
    .i_be    (s.wstrb),
    .i_waddr (r_waddr),
    .i_wdata (s.wdata),
    .i_re    (r_rstate == R_FETCH),
    .i_raddr (r_raddr),
    .o_rdata (w_ram_rdata)
  );

  assign s.awready = r_awready;
  assign s.wready  = r_wready;
  assign s.bvalid  = r_bvalid;
  assign s.bresp   = r_bresp;
  assign s.arready = r_arready;
  assign s.rvalid  = r_rvalid;
  assign s.rlast   = r_rlast;
  assign s.rresp   = r_rresp;
  // Failed-check reads return zero data.
  assign s.rdata   = r_rfatal ? '0 : w_ram_rdata;

  // Fields the responder samples but never acts on.
  assign w_unused = ^{s.awid, s.awaddr, s.awsize, s.awlock, s.awcache, s.awprot, s.awqos,
                      s.arid, s.araddr, s.arsize, s.arlock, s.arcache, s.arprot, s.arqos,
                      s.wlast};
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Self-checking bench for axi4_mem_responder against a word-array memory model.
module tb_axi4_mem_responder;
  import axi4_pkg::*;

  localparam int AW    = 10;
  localparam int Depth = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi4_ifc ifc ();

  axi4_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s     (ifc)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] refmem [Depth];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic bit check_en();
`ifdef AXI4_MEM_RESPONDER_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_fatal(input logic [2:0] size, input logic [1:0] burst);
    return check_en() && ((size != 3'd2) || (burst == 2'b10) || (burst == 2'b11));
  endfunction

  function automatic int word_idx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    int base;
    base = int'(addr[AW+1:2]);
    return (base + ((burst == 2'b00) ? 0 : beat)) % Depth;
  endfunction

  // Sends `beats` W beats (fewer than len+1 leaves the burst open and skips B).
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int last_at, input int bdelay,
                           input int beats, input string tag);
    int n;
    bit fatal, lbad;
    logic [1:0] er;
    int k;
    chk({tag, ":wready_idle"}, {31'd0, ifc.wready}, 32'd0);
    ifc.awaddr = addr; ifc.awlen = len[7:0]; ifc.awsize = size; ifc.awburst = burst;
    ifc.awvalid = 1'b1;
    n = 0;
    while (ifc.awready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n == 20) begin timeout({tag, ":aw"}); ifc.awvalid = 1'b0; return; end
    tick();
    ifc.awvalid = 1'b0;
    fatal = exp_fatal(size, burst);
    lbad = 1'b0;
    for (int i = 0; i <= len && i < beats; i++) begin
      ifc.wdata = wbuf[i]; ifc.wstrb = sbuf[i]; ifc.wlast = (i == last_at); ifc.wvalid = 1'b1;
      chk($sformatf("%s:wready_beat%0d", tag, i), {31'd0, ifc.wready}, 32'd1);
      if ((i == last_at) != (i == len)) lbad = 1'b1;
      tick();
      if (!fatal) begin
        k = word_idx(addr, burst, i);
        for (int b = 0; b < 4; b++) if (sbuf[i][b]) refmem[k][8*b +: 8] = wbuf[i][8*b +: 8];
      end
    end
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    if (beats <= len) return;
    er = (fatal || (check_en() && lbad)) ? RESP_SLVERR : RESP_OKAY;
    chk({tag, ":bvalid_rise"}, {31'd0, ifc.bvalid}, 32'd1);
    chk({tag, ":bresp"}, {30'd0, ifc.bresp}, {30'd0, er});
    for (int d = 0; d < bdelay; d++) begin
      tick();
      chk({tag, ":bvalid_hold"}, {31'd0, ifc.bvalid}, 32'd1);
      chk({tag, ":bresp_hold"}, {30'd0, ifc.bresp}, {30'd0, er});
    end
    ifc.bready = 1'b1;
    tick();
    ifc.bready = 1'b0;
    chk({tag, ":bvalid_drop"}, {31'd0, ifc.bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int rdelay, input string tag);
    int n;
    bit fatal;
    logic [31:0] ed;
    logic [1:0] er;
    ifc.araddr = addr; ifc.arlen = len[7:0]; ifc.arsize = size; ifc.arburst = burst;
    ifc.arvalid = 1'b1;
    n = 0;
    while (ifc.arready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n == 20) begin timeout({tag, ":ar"}); ifc.arvalid = 1'b0; return; end
    tick();
    ifc.arvalid = 1'b0;
    fatal = exp_fatal(size, burst);
    er = fatal ? RESP_SLVERR : RESP_OKAY;
    for (int i = 0; i <= len; i++) begin
      chk($sformatf("%s:rvalid_gap%0d", tag, i), {31'd0, ifc.rvalid}, 32'd0);
      tick();
      ed = fatal ? 32'd0 : refmem[word_idx(addr, burst, i)];
      chk($sformatf("%s:rvalid%0d", tag, i), {31'd0, ifc.rvalid}, 32'd1);
      chk($sformatf("%s:rdata%0d", tag, i), ifc.rdata, ed);
      chk($sformatf("%s:rlast%0d", tag, i), {31'd0, ifc.rlast}, {31'd0, i == len});
      chk($sformatf("%s:rresp%0d", tag, i), {30'd0, ifc.rresp}, {30'd0, er});
      for (int d = 0; d < rdelay; d++) begin
        tick();
        chk($sformatf("%s:rvalid_hold%0d", tag, i), {31'd0, ifc.rvalid}, 32'd1);
        chk($sformatf("%s:rdata_hold%0d", tag, i), ifc.rdata, ed);
        chk($sformatf("%s:rlast_hold%0d", tag, i), {31'd0, ifc.rlast}, {31'd0, i == len});
      end
      ifc.rready = 1'b1;
      tick();
      ifc.rready = 1'b0;
    end
    chk({tag, ":rvalid_end"}, {31'd0, ifc.rvalid}, 32'd0);
    chk({tag, ":arready_end"}, {31'd0, ifc.arready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int len;
    logic [1:0] burst;
    logic [2:0] size;

    ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = 3'd2; ifc.awburst = 2'b01;
    ifc.awlock = 1'b0; ifc.awcache = '0; ifc.awprot = '0; ifc.awqos = '0; ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0; ifc.bready = 1'b0;
    ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = 3'd2; ifc.arburst = 2'b01;
    ifc.arlock = 1'b0; ifc.arcache = '0; ifc.arprot = '0; ifc.arqos = '0; ifc.arvalid = 1'b0;
    ifc.rready = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_awready", {31'd0, ifc.awready}, 32'd0);
    chk("rst_wready",  {31'd0, ifc.wready},  32'd0);
    chk("rst_bvalid",  {31'd0, ifc.bvalid},  32'd0);
    chk("rst_bresp",   {30'd0, ifc.bresp},   32'd0);
    chk("rst_arready", {31'd0, ifc.arready}, 32'd0);
    chk("rst_rvalid",  {31'd0, ifc.rvalid},  32'd0);
    chk("rst_rlast",   {31'd0, ifc.rlast},   32'd0);
    chk("rst_rresp",   {30'd0, ifc.rresp},   32'd0);
    chk("rst_rdata",   ifc.rdata,            32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_awready", {31'd0, ifc.awready}, 32'd1);
    chk("post_rst_arready", {31'd0, ifc.arready}, 32'd1);

    // Fill the whole memory so every model word is defined
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      axi_write(32'(blk * 1024), 255, 2'b01, 3'd2, 255, 0, 256, "fill");
    end

    // Single beat
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    axi_write(32'h10, 0, 2'b01, 3'd2, 0, 0, 256, "single_wr");
    axi_read(32'h10, 0, 2'b01, 3'd2, 0, "single_rd");

    // INCR 16 beats of beat index
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
    axi_write(32'h100, 15, 2'b01, 3'd2, 15, 0, 256, "incr_wr");
    axi_read(32'h100, 15, 2'b01, 3'd2, 0, "incr_rd");

    // FIXED 4 beats: last beat survives
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(32'h40, 3, 2'b00, 3'd2, 3, 0, 256, "fixed_wr");
    axi_read(32'h40, 0, 2'b01, 3'd2, 0, "fixed_rd");

    // Strobes
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
    axi_write(32'h200, 0, 2'b01, 3'd2, 0, 0, 256, "strb_wr1");
    wbuf[0] = 32'h00000000; sbuf[0] = 4'h5;
    axi_write(32'h200, 0, 2'b01, 3'd2, 0, 0, 256, "strb_wr2");
    axi_read(32'h200, 0, 2'b01, 3'd2, 0, "strb_rd");

    // Backpressure
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(32'h280, 3, 2'b01, 3'd2, 3, 5, 256, "bp_wr");
    axi_read(32'h280, 3, 2'b01, 3'd2, 5, "bp_rd");

    // Protocol checks: narrow size, then early wlast on beat 2 of 4
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h5A5A0000 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(32'h300, 3, 2'b01, 3'd1, 3, 0, 256, "size_wr");
    axi_read(32'h300, 3, 2'b01, 3'd2, 0, "size_rd");
    axi_write(32'h320, 3, 2'b01, 3'd2, 1, 0, 256, "wlast_wr");
    axi_read(32'h320, 3, 2'b01, 3'd2, 0, "wlast_rd");

    // Reset after beat 3 of 8
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hC0DE0000 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(32'h380, 7, 2'b01, 3'd2, 7, 0, 3, "abort_wr");
    reset = 1'b1;
    tick();
    chk("abort_bvalid",  {31'd0, ifc.bvalid},  32'd0);
    chk("abort_wready",  {31'd0, ifc.wready},  32'd0);
    chk("abort_awready", {31'd0, ifc.awready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("abort_bvalid_after", {31'd0, ifc.bvalid},  32'd0);
    chk("abort_awready_after", {31'd0, ifc.awready}, 32'd1);
    axi_read(32'h380, 7, 2'b01, 3'd2, 0, "abort_rd");
    for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(32'h380, 7, 2'b01, 3'd2, 7, 0, 256, "post_abort_wr");
    axi_read(32'h380, 7, 2'b01, 3'd2, 0, "post_abort_rd");

    // Randomized bursts across the full address space (upper bits ignored, index wraps)
    for (int t = 0; t < 30; t++) begin
      addr  = $urandom;
      len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 7));
      burst = 2'($urandom_range(0, 3));
      size  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
      axi_write(addr, len, burst, size, len, int'($urandom_range(0, 3)), 256, "rnd_wr");
      axi_read(addr, len, burst, 3'd2, int'($urandom_range(0, 3)), "rnd_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
